adc_sample_packetizer: RTL and testbench

ADC_SAMPLE_PACKETIZER -- requirements
Module: adc_sample_packetizer

---
 rtl/adc_sample_packetizer_pkg.sv | 7 +
 rtl/adc_sample_packetizer_if.sv | 15 +
 rtl/adc_sample_packetizer_sample_fifo.sv | 34 +++
 rtl/adc_sample_packetizer.sv | 66 ++++++
 tb/tb_adc_sample_packetizer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sample_packetizer_pkg.sv
// adc_sample_packetizer_pkg: shared beat width and output FSM state encoding.
package adc_sample_packetizer_pkg;
    localparam int BEAT_WIDTH = 16;
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t EMIT = 1'b1;
endpackage

// File: rtl/adc_sample_packetizer_if.sv
// adc_sample_packetizer_if: sample strobe input and AXI-stream style beat output.
interface adc_sample_packetizer_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 14
);
    import adc_sample_packetizer_pkg::*;
    logic IN_VALID;
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] IN_DATA;
    logic M_TVALID;
    logic M_TREADY;
    logic [BEAT_WIDTH-1:0] M_TDATA;
    logic M_TLAST;
    modport master (input IN_VALID, IN_DATA, M_TREADY, output M_TVALID, M_TDATA, M_TLAST);
    modport slave (output IN_VALID, IN_DATA, M_TREADY, input M_TVALID, M_TDATA, M_TLAST);
endinterface

// File: rtl/adc_sample_packetizer_sample_fifo.sv
// sample_fifo: power-of-2 depth FIFO with combinational head; caller guards overflow/underflow.
module sample_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= wr_data;
    assign rd_data = mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/adc_sample_packetizer.sv
// adc_sample_packetizer: decimates ADC sample vectors, buffers them and emits one channel per beat in packets.
module adc_sample_packetizer
    import adc_sample_packetizer_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int PACKET_SAMPLES = 64
) (
    input  logic AXI_CLK,
    input  logic RESET,
    input  logic ENABLE,
    input  logic [7:0] DECIM,
    adc_sample_packetizer_if.master bus,
    output logic [15:0] OVERFLOW_COUNT
);
    localparam int VW = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int PW = PACKET_SAMPLES > 1 ? $clog2(PACKET_SAMPLES) : 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    state_t state;
    logic [7:0] dec_cnt, dec_last;
    logic [CW-1:0] ch;
    logic [PW-1:0] pkt;
    logic push, hs, pop, wr_en, full, empty, last_ch;
    logic [FW-1:0] count;
    logic [VW-1:0] head;
    assign dec_last = DECIM == 8'd0 ? 8'd0 : DECIM - 8'd1;
    assign push = bus.IN_VALID && ENABLE && dec_cnt == 8'd0;
    assign last_ch = ch == CW'(NUM_CHANNELS - 1);
    assign hs = bus.M_TVALID && bus.M_TREADY;
    assign pop = hs && last_ch;
    // a full FIFO still takes the write when the head leaves on the same edge
    assign wr_en = push && (!full || pop);
    sample_fifo #(.WIDTH(VW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(AXI_CLK),
        .rst(RESET),
        .wr_en(wr_en),
        .wr_data(bus.IN_DATA),
        .rd_en(pop),
        .rd_data(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign bus.M_TVALID = state == EMIT;
    assign bus.M_TDATA = bus.M_TVALID ? BEAT_WIDTH'(head[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH]) : '0;
    assign bus.M_TLAST = bus.M_TVALID && last_ch && pkt == PW'(PACKET_SAMPLES - 1);
    always_ff @(posedge AXI_CLK) begin
        if (RESET) begin
            state <= IDLE;
            dec_cnt <= '0;
            ch <= '0;
            pkt <= '0;
            OVERFLOW_COUNT <= '0;
        end else begin
            // EMIT tracks "FIFO non-empty after this edge", giving a one-cycle push-to-valid latency
            state <= (wr_en || (!empty && !(pop && count == FW'(1)))) ? EMIT : IDLE;
            if (!ENABLE) dec_cnt <= '0;
            else if (bus.IN_VALID) dec_cnt <= dec_cnt >= dec_last ? 8'd0 : dec_cnt + 8'd1;
            if (hs) ch <= last_ch ? '0 : ch + CW'(1);
            if (pop) pkt <= pkt == PW'(PACKET_SAMPLES - 1) ? '0 : pkt + PW'(1);
            if (push && full && !pop && OVERFLOW_COUNT != 16'hFFFF) OVERFLOW_COUNT <= OVERFLOW_COUNT + 16'd1;
        end
    end
endmodule

// File: tb/tb_adc_sample_packetizer.sv
// tb_adc_sample_packetizer: directed scenarios with a beat scoreboard and hold-while-stalled checks.
module tb_adc_sample_packetizer;
    localparam int NC = 4;
    localparam int SW = 14;
    localparam int VW = NC * SW;
    logic clk = 1'b0;
    logic rst, enable;
    logic [7:0] decim;
    logic [15:0] ovf;
    adc_sample_packetizer_if #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW)) bus ();
    adc_sample_packetizer #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(16), .PACKET_SAMPLES(64)) dut (
        .AXI_CLK(clk),
        .RESET(rst),
        .ENABLE(enable),
        .DECIM(decim),
        .bus(bus),
        .OVERFLOW_COUNT(ovf)
    );
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    int beats = 0;
    int vec_idx = 0;
    int dcnt = 0;
    int ovf_exp = 0;
    logic [16:0] exp_q [$];
    logic prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && bus.M_TVALID) begin
                check("hold_data", 32'(bus.M_TDATA), 32'(prev_data));
                check("hold_last", 32'(bus.M_TLAST), 32'(prev_last));
            end
            if (bus.M_TVALID && bus.M_TREADY) begin
                beats++;
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL beat_unexpected got=%0h exp=none", {bus.M_TLAST, bus.M_TDATA});
                end
                if (exp_q.size() > 0) check("beat", 32'({bus.M_TLAST, bus.M_TDATA}), 32'(exp_q.pop_front()));
            end
        end
        prev_stall = !rst && bus.M_TVALID && !bus.M_TREADY;
        prev_data = bus.M_TDATA;
        prev_last = bus.M_TLAST;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] mk(input int i);
        return {14'(i + 'hD00), 14'(i + 'hC00), 14'(i + 'hB00), 14'(i + 'hA00)};
    endfunction

    // decimation and packet-position model; drop says the FIFO is expected to be full with no pop
    task automatic strobe(input logic [VW-1:0] d, input bit drop);
        int dv;
        bit push;
        logic l;
        dv = decim == 8'd0 ? 1 : int'(decim);
        push = 1'b0;
        if (enable) begin
            push = dcnt == 0;
            dcnt = dcnt + 1 >= dv ? 0 : dcnt + 1;
        end
        if (push && drop) ovf_exp++;
        if (push && !drop) begin
            for (int c = 0; c < NC; c++) begin
                l = c == NC - 1 && vec_idx % 64 == 63;
                exp_q.push_back({l, 16'(d[c*SW +: SW])});
            end
            vec_idx++;
        end
        bus.IN_VALID = 1'b1;
        bus.IN_DATA = d;
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int b0, n;
        logic [63:0] r;
        rst = 1'b1;
        enable = 1'b0;
        decim = 8'd1;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA = '0;
        bus.M_TREADY = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(bus.M_TVALID), 32'd0);
        check("rst_data", 32'(bus.M_TDATA), 32'd0);
        check("rst_last", 32'(bus.M_TLAST), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        enable = 1'b1;
        tick();
        // full packet at DECIM=1, one vector every 4 cycles
        bus.M_TREADY = 1'b1;
        for (int i = 0; i < 64; i++) begin
            strobe(mk(i), 1'b0);
            if (i == 0) begin
                check("lat1_valid", 32'(bus.M_TVALID), 32'd1);
                check("lat1_data", 32'(bus.M_TDATA), 32'h0A00);
            end
            repeat (3) tick();
        end
        drain("t1_drain", 100);
        check("t1_beats", 32'(beats), 32'd256);
        // ENABLE low ignores strobes, then DECIM=3 keeps strobes 1,4,7
        enable = 1'b0;
        tick();
        dcnt = 0;
        strobe(mk(100), 1'b0);
        enable = 1'b1;
        decim = 8'd3;
        tick();
        b0 = beats;
        for (int i = 1; i <= 9; i++) begin
            strobe(mk(200 + i), 1'b0);
            tick();
        end
        drain("t2_drain", 100);
        check("t2_beats", 32'(beats - b0), 32'd12);
        // stalled output: 20 pushes, 4 dropped, then 64 back-to-back beats
        decim = 8'd1;
        bus.M_TREADY = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) strobe(mk(300 + i), i >= 16);
        tick();
        check("t3_ovf", 32'(ovf), 32'(ovf_exp));
        check("t3_valid", 32'(bus.M_TVALID), 32'd1);
        b0 = beats;
        bus.M_TREADY = 1'b1;
        repeat (64) tick();
        check("t3_nobubble", 32'(beats - b0), 32'd64);
        check("t3_empty", 32'(exp_q.size()), 32'd0);
        // full FIFO: write lands on the same edge as the head pop
        bus.M_TREADY = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) strobe(mk(400 + i), 1'b0);
        check("t4_full_ovf", 32'(ovf), 32'(ovf_exp));
        bus.M_TREADY = 1'b1;
        repeat (3) tick();
        strobe(mk(416), 1'b0);
        check("t4_ovf", 32'(ovf), 32'(ovf_exp));
        drain("t4_drain", 200);
        // reset at beat 100 of a packet with data still buffered
        b0 = beats;
        for (int i = 0; i < 25; i++) begin
            strobe(mk(500 + i), 1'b0);
            repeat (3) tick();
        end
        n = 0;
        while (beats - b0 < 100 && n < 50) begin
            tick();
            n++;
        end
        check("t5_beat100", 32'(beats - b0), 32'd100);
        bus.M_TREADY = 1'b0;
        for (int i = 0; i < 3; i++) strobe(mk(600 + i), 1'b0);
        rst = 1'b1;
        tick();
        check("t5_rst_valid", 32'(bus.M_TVALID), 32'd0);
        check("t5_rst_data", 32'(bus.M_TDATA), 32'd0);
        check("t5_rst_last", 32'(bus.M_TLAST), 32'd0);
        check("t5_rst_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        vec_idx = 0;
        dcnt = 0;
        ovf_exp = 0;
        rst = 1'b0;
        tick();
        check("t5_post_valid", 32'(bus.M_TVALID), 32'd0);
        b0 = beats;
        bus.M_TREADY = 1'b1;
        for (int i = 0; i < 64; i++) begin
            strobe(mk(700 + i), 1'b0);
            repeat (3) tick();
        end
        drain("t5_drain", 100);
        check("t5_beats", 32'(beats - b0), 32'd256);
        // random backpressure with random sample data
        b0 = beats;
        for (int i = 0; i < 20; i++) begin
            r = {$urandom(), $urandom()};
            bus.M_TREADY = $urandom_range(0, 3) != 0;
            strobe(r[VW-1:0], 1'b0);
            for (int c = 0; c < 7; c++) begin
                bus.M_TREADY = $urandom_range(0, 3) != 0;
                tick();
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            bus.M_TREADY = $urandom_range(0, 1) != 0;
            tick();
            n++;
        end
        check("t6_drain", 32'(exp_q.size()), 32'd0);
        check("t6_beats", 32'(beats - b0), 32'd80);
        check("t6_ovf", 32'(ovf), 32'(ovf_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
